// File: rtl/ola_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ola_pkg
//  Description : Shared types and sizing helpers for the overlap-add framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ola_pkg;

    // Framer / accumulator sequencing
    typedef enum logic [2:0] {
        FILL  = 3'd0,
        PAD   = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } ola_state_e;

    // Index width for a memory of the given depth (never narrower than 1 bit)
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must be able to hold the value maxval itself
    function automatic int cnt_w(input int maxval);
        return $clog2(maxval + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ola_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : ola_sat_add
//  Description : Combinational signed saturating adder with overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ola_sat_add
    import ola_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_sum,
    output logic                         o_ovf
);

    localparam logic signed [DATA_WIDTH-1:0] c_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH:0] w_full;

    // One guard bit; the two top bits disagree exactly when the result is out of range
    always_comb begin
        w_full = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};
        o_ovf  = w_full[DATA_WIDTH] ^ w_full[DATA_WIDTH-1];
        if (!o_ovf) begin
            o_sum = w_full[DATA_WIDTH-1:0];
        end else if (w_full[DATA_WIDTH]) begin
            o_sum = c_MIN;
        end else begin
            o_sum = c_MAX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/overlap_add_stream.sv
`default_nettype none
// ============================================================================
//  Module      : overlap_add_stream
//  Description : Cuts a sample stream into N-point windows advanced by
//                HOP = N-OVERLAP, streams each window to the FFT core and
//                overlap-adds the returned frames with saturation. The last
//                window is zero-padded and the OVERLAP-sample tail flushed.
//  Revision    : 1.0 - initial release
// ============================================================================
module overlap_add_stream
    import ola_pkg::*;
#(
    parameter int N          = 128,
    parameter int OVERLAP    = 64,
    parameter int DATA_WIDTH = 16,
    parameter int COMPLEX_IN = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din_re,
    input  logic [DATA_WIDTH-1:0] din_im,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_last,
    output logic                  di_en,
    output logic [DATA_WIDTH-1:0] di_re,
    output logic [DATA_WIDTH-1:0] di_im,
    input  logic                  do_en,
    input  logic [DATA_WIDTH-1:0] do_re,
    input  logic [DATA_WIDTH-1:0] do_im,
    output logic [DATA_WIDTH-1:0] dout_re,
    output logic [DATA_WIDTH-1:0] dout_im,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  overflow,
    output logic                  done
);

    localparam int DW   = DATA_WIDTH;
    localparam int c_HOP = N - OVERLAP;
    localparam int c_PW  = ptr_w(N);
    localparam int c_CW  = cnt_w(N);
    localparam int c_OW  = ptr_w(OVERLAP);

    localparam logic [c_PW-1:0] c_LAST_K  = c_PW'(N - 1);
    localparam logic [c_PW-1:0] c_HOP_K   = c_PW'(c_HOP);
    localparam logic [c_PW-1:0] c_OV_K    = c_PW'(OVERLAP);
    localparam logic [c_OW-1:0] c_OV_LAST = c_OW'(OVERLAP - 1);
    localparam logic [c_CW-1:0] c_TGT_N   = c_CW'(N);
    localparam logic [c_CW-1:0] c_TGT_HOP = c_CW'(c_HOP);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    ola_state_e      r_state;
    ola_state_e      w_state_nx;
    logic [c_PW-1:0] r_wptr;
    logic [c_CW-1:0] r_cnt;
    logic [c_PW-1:0] r_fcnt;
    logic [c_PW-1:0] r_k;
    logic [c_OW-1:0] r_fl;
    logic            r_first_frame;
    logic            r_last_window;

    logic            r_din_ready;
    logic            r_done;
    logic            r_di_en;
    logic [DW-1:0]   r_di_re;
    logic [DW-1:0]   r_di_im;
    logic [DW-1:0]   r_dout_re;
    logic [DW-1:0]   r_dout_im;
    logic            r_dout_valid;
    logic            r_dout_last;
    logic            r_overflow;

    logic [DW-1:0]   r_win_re [N];
    logic [2*DW-1:0] r_ov_mem [OVERLAP];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic            w_accept;
    logic [c_CW-1:0] w_target;
    logic [c_CW-1:0] w_cnt_inc;
    logic            w_cnt_hit;
    logic            w_wr_en;
    logic            w_wr_zero;
    logic            w_set_last;
    logic            w_emit;
    logic            w_ov_we;
    logic            w_ov_use;
    logic [c_PW-1:0] w_rptr;
    logic [c_OW-1:0] w_ov_raddr;
    logic [c_OW-1:0] w_ov_waddr;
    logic [2*DW-1:0] w_ov_rd;
    logic [DW-1:0]   w_rd_re;
    logic [DW-1:0]   w_rd_im;
    logic [DW-1:0]   w_add_b_re;
    logic [DW-1:0]   w_add_b_im;
    logic [DW-1:0]   w_sum_re;
    logic [DW-1:0]   w_sum_im;
    logic            w_ovf_re;
    logic            w_ovf_im;

    // The first window needs a full N samples, later ones only the new HOP
    assign w_target  = r_first_frame ? c_TGT_N : c_TGT_HOP;
    assign w_cnt_inc = r_cnt + c_CW'(1);
    assign w_cnt_hit = (w_cnt_inc == w_target);
    assign w_accept  = din_valid & r_din_ready & (r_state == FILL);

    // Oldest sample sits at the write pointer, so reading starts there
    assign w_rptr  = r_wptr + r_fcnt;
    assign w_rd_re = r_win_re[w_rptr];

    // One overlap buffer suffices: slots 0..OVERLAP-1 are read before k reaches HOP
    assign w_ov_raddr = (r_state == FLUSH) ? r_fl : r_k[c_OW-1:0];
    assign w_ov_waddr = c_OW'(r_k - c_HOP_K);
    assign w_ov_rd    = r_ov_mem[w_ov_raddr];

    // Stale overlap contents are masked on the first frame after reset
    assign w_ov_use   = !r_first_frame && (r_k < c_OV_K);
    assign w_add_b_re = w_ov_use ? w_ov_rd[2*DW-1:DW] : '0;
    assign w_add_b_im = w_ov_use ? w_ov_rd[DW-1:0]    : '0;

    ola_sat_add #(.DATA_WIDTH(DW)) u_add_re (
        .i_a   (do_re),
        .i_b   (w_add_b_re),
        .o_sum (w_sum_re),
        .o_ovf (w_ovf_re)
    );

    ola_sat_add #(.DATA_WIDTH(DW)) u_add_im (
        .i_a   (do_im),
        .i_b   (w_add_b_im),
        .o_sum (w_sum_im),
        .o_ovf (w_ovf_im)
    );

    // Imaginary window storage exists only for complex input
    generate
        if (COMPLEX_IN != 0) begin : g_cplx
            logic [DW-1:0] r_win_im [N];

            // Imaginary window buffer write, zero during padding
            always_ff @(posedge clock) begin
                if (w_wr_en) begin
                    r_win_im[r_wptr] <= w_wr_zero ? '0 : din_im;
                end
            end

            assign w_rd_im = r_win_im[w_rptr];
        end else begin : g_real
            logic w_unused_im;
            assign w_unused_im = ^din_im;
            assign w_rd_im     = '0;
        end
    endgenerate

    // Next-state and per-cycle strobes
    always_comb begin
        w_state_nx = r_state;
        w_wr_en    = 1'b0;
        w_wr_zero  = 1'b0;
        w_set_last = 1'b0;
        w_emit     = 1'b0;
        w_ov_we    = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (w_cnt_hit) begin
                        w_set_last = din_last;
                        w_state_nx = FEED;
                    end else if (din_last) begin
                        w_set_last = 1'b1;
                        w_state_nx = PAD;
                    end
                end
            end
            PAD: begin
                w_wr_en   = 1'b1;
                w_wr_zero = 1'b1;
                if (w_cnt_hit) begin
                    w_state_nx = FEED;
                end
            end
            FEED: begin
                if (r_fcnt == c_LAST_K) begin
                    w_state_nx = WAIT;
                end
            end
            WAIT: begin
                if (do_en) begin
                    w_emit  = (r_k < c_HOP_K);
                    w_ov_we = (r_k >= c_HOP_K);
                    if (r_k == c_LAST_K) begin
                        w_state_nx = r_last_window ? FLUSH : FILL;
                    end
                end
            end
            FLUSH: begin
                if (r_fl == c_OV_LAST) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_state_nx = DONE;
            end
            default: begin
                w_state_nx = FILL;
            end
        endcase
    end

    // State register plus the outputs that depend only on the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= FILL;
            r_din_ready <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_din_ready <= (w_state_nx == FILL);
            r_done      <= (w_state_nx == DONE);
        end
    end

    // Window buffer write: accepted samples or padding zeros
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_win_re[r_wptr] <= w_wr_zero ? '0 : din_re;
        end
    end

    // Overlap buffer write: second half of each returned frame
    always_ff @(posedge clock) begin
        if (w_ov_we) begin
            r_ov_mem[w_ov_waddr] <= {do_re, do_im};
        end
    end

    // Pointers, counters, flags and registered stream outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr        <= '0;
            r_cnt         <= '0;
            r_fcnt        <= '0;
            r_k           <= '0;
            r_fl          <= '0;
            r_first_frame <= 1'b1;
            r_last_window <= 1'b0;
            r_di_en       <= 1'b0;
            r_di_re       <= '0;
            r_di_im       <= '0;
            r_dout_re     <= '0;
            r_dout_im     <= '0;
            r_dout_valid  <= 1'b0;
            r_dout_last   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_di_en      <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;

            if (w_wr_en) begin
                r_wptr <= r_wptr + c_PW'(1);
                r_cnt  <= w_cnt_inc;
            end
            if (w_set_last) begin
                r_last_window <= 1'b1;
            end

            if (r_state == FEED) begin
                r_di_en <= 1'b1;
                r_di_re <= w_rd_re;
                r_di_im <= w_rd_im;
                r_fcnt  <= r_fcnt + c_PW'(1);
                r_cnt   <= '0;
            end

            if ((r_state == WAIT) && do_en) begin
                r_k <= r_k + c_PW'(1);
                if (r_k == c_LAST_K) begin
                    r_first_frame <= 1'b0;
                end
            end
            if (w_emit) begin
                r_dout_re    <= w_sum_re;
                r_dout_im    <= w_sum_im;
                r_dout_valid <= 1'b1;
                if (w_ovf_re || w_ovf_im) begin
                    r_overflow <= 1'b1;
                end
            end

            if (r_state == FLUSH) begin
                r_dout_re    <= w_ov_rd[2*DW-1:DW];
                r_dout_im    <= w_ov_rd[DW-1:0];
                r_dout_valid <= 1'b1;
                r_dout_last  <= (r_fl == c_OV_LAST);
                r_fl         <= r_fl + c_OW'(1);
            end
        end
    end

    assign din_ready  = r_din_ready;
    assign done       = r_done;
    assign di_en      = r_di_en;
    assign di_re      = r_di_re;
    assign di_im      = r_di_im;
    assign dout_re    = r_dout_re;
    assign dout_im    = r_dout_im;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_overlap_add_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_overlap_add_stream
//  Description : Self-checking bench for overlap_add_stream (N=8, OVERLAP=4)
//                with a frame-based identity FFT model and a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_overlap_add_stream;

    localparam int N   = 8;
    localparam int OV  = 4;
    localparam int HOP = N - OV;
    localparam int DW  = 16;

    typedef struct packed {
        logic [DW-1:0] re;
        logic          last;
    } out_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] din_re = '0;
    logic [DW-1:0] din_im = 16'h1234;
    logic          din_valid = 1'b0;
    logic          din_last = 1'b0;
    logic          din_ready;
    logic          di_en;
    logic [DW-1:0] di_re;
    logic [DW-1:0] di_im;
    logic          do_en;
    logic [DW-1:0] do_re;
    logic [DW-1:0] do_im;
    logic [DW-1:0] dout_re;
    logic [DW-1:0] dout_im;
    logic          dout_valid;
    logic          dout_last;
    logic          overflow;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    int            n_dout = 0;
    logic [DW-1:0] xs[$];
    logic [DW-1:0] exp_di[$];
    out_t          exp_out[$];
    logic          exp_ovf = 1'b0;
    out_t          mon_e;

    overlap_add_stream #(
        .N          (N),
        .OVERLAP    (OV),
        .DATA_WIDTH (DW),
        .COMPLEX_IN (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_last   (din_last),
        .di_en      (di_en),
        .di_re      (di_re),
        .di_im      (di_im),
        .do_en      (do_en),
        .do_re      (do_re),
        .do_im      (do_im),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Identity FFT: collect a whole frame, then replay it 5 cycles later
    logic [DW-1:0] m_re [N];
    logic [DW-1:0] m_im [N];
    int            m_in, m_wait, m_out;
    logic          m_act;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_in <= 0; m_wait <= 0; m_out <= 0; m_act <= 1'b0;
            do_en <= 1'b0; do_re <= '0; do_im <= '0;
        end else begin
            do_en <= 1'b0;
            if (di_en) begin
                m_re[m_in] <= di_re;
                m_im[m_in] <= di_im;
                if (m_in == N - 1) begin
                    m_in   <= 0;
                    m_wait <= 5;
                end else begin
                    m_in <= m_in + 1;
                end
            end
            if (m_wait > 0) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_act <= 1'b1;
                    m_out <= 0;
                end
            end
            if (m_act) begin
                do_en <= 1'b1;
                do_re <= m_re[m_out];
                do_im <= m_im[m_out];
                if (m_out == N - 1) m_act <= 1'b0;
                else                m_out <= m_out + 1;
            end
        end
    end

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endfunction

    // Scoreboard: compare every FFT-input strobe and every output sample
    always @(negedge clock) begin
        if (!reset) begin
            if (di_en) begin
                if (exp_di.size() == 0) chk("di_extra", 32'd1, 32'd0);
                else                    chk("di_re", 32'(di_re), 32'(exp_di.pop_front()));
                chk("di_im", 32'(di_im), 32'd0);
            end
            if (dout_valid) begin
                n_dout++;
                if (exp_out.size() == 0) begin
                    chk("dout_extra", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_out.pop_front();
                    chk("dout_re", 32'(dout_re), 32'(mon_e.re));
                    chk("dout_last", 32'(dout_last), 32'(mon_e.last));
                end
                chk("dout_im", 32'(dout_im), 32'd0);
            end
        end
    end

    // Reference model: pad, cut windows, sum the (at most two) covering windows
    task automatic build_expect();
        int            l, lp, nw, cov, sv;
        logic [DW-1:0] xp[$];
        out_t          o;
        l  = xs.size();
        lp = (l <= N) ? N : N + ((l - N + HOP - 1) / HOP) * HOP;
        xp = xs;
        while (xp.size() < lp) xp.push_back('0);
        nw = (lp - N) / HOP + 1;
        for (int w = 0; w < nw; w++)
            for (int k = 0; k < N; k++) exp_di.push_back(xp[w * HOP + k]);
        exp_ovf = 1'b0;
        for (int i = 0; i < lp; i++) begin
            cov = 0;
            for (int w = 0; w < nw; w++)
                if (i >= w * HOP && i < w * HOP + N) cov++;
            sv = int'($signed(xp[i])) * cov;
            if (sv > 32767) begin
                o.re = 16'h7FFF; exp_ovf = 1'b1;
            end else if (sv < -32768) begin
                o.re = 16'h8000; exp_ovf = 1'b1;
            end else begin
                o.re = sv[15:0];
            end
            o.last = (i == lp - 1);
            exp_out.push_back(o);
        end
    endtask

    task automatic send(input logic [DW-1:0] v, input logic last, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
        din_re = v; din_last = last; din_valid = 1'b1; t = 0;
        while (din_ready !== 1'b1 && t < 1000) begin
            @(negedge clock);
            t++;
        end
        chk("ready_wait", 32'(t < 1000), 32'd1);
        @(negedge clock);
        din_valid = 1'b0; din_last = 1'b0;
    endtask

    task automatic run_stream(input bit gaps);
        int t;
        build_expect();
        for (int i = 0; i < xs.size(); i++) send(xs[i], (i == xs.size() - 1), gaps);
        chk("ready_low_after_last", 32'(din_ready), 32'd0);
        t = 0;
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        chk("done", 32'(done), 32'd1);
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("di_queue_empty", 32'(exp_di.size()), 32'd0);
        chk("dout_queue_empty", 32'(exp_out.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; din_valid = 1'b0; din_last = 1'b0;
        repeat (2) @(negedge clock);
        exp_di.delete(); exp_out.delete();
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int   t;
        out_t o;
        repeat (3) @(negedge clock);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_di_en", 32'(di_en), 32'd0);
        chk("rst_di_re", 32'(di_re), 32'd0);
        chk("rst_di_im", 32'(di_im), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout_re", 32'(dout_re), 32'd0);
        chk("rst_dout_last", 32'(dout_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 32'(din_ready), 32'd1);

        // 16-sample ramp, last exactly on a window boundary
        xs.delete();
        for (int i = 1; i <= 16; i++) xs.push_back(16'(i));
        run_stream(1'b0);

        // Last on sample 10: two padding zeros
        apply_reset();
        xs.delete();
        for (int i = 1; i <= 10; i++) xs.push_back(16'(i));
        run_stream(1'b0);

        // Positive saturation with input gaps
        apply_reset();
        chk("ovf_clear_after_reset", 32'(overflow), 32'd0);
        xs.delete();
        for (int i = 0; i < 16; i++) xs.push_back(16'h7000);
        run_stream(1'b1);

        // Negative saturation with input gaps
        apply_reset();
        xs.delete();
        for (int i = 0; i < 16; i++) xs.push_back(16'h9000);
        run_stream(1'b1);

        // Abort in the middle of the first frame's output
        apply_reset();
        xs.delete();
        for (int i = 0; i < N; i++) xs.push_back(16'(16'h0011 * (i + 1)));
        for (int i = 0; i < N; i++) exp_di.push_back(xs[i]);
        for (int i = 0; i < HOP; i++) begin
            o.re = xs[i]; o.last = 1'b0;
            exp_out.push_back(o);
        end
        n_dout = 0;
        for (int i = 0; i < N; i++) send(xs[i], 1'b0, 1'b1);
        t = 0;
        while (n_dout < 1 && t < 500) begin
            @(negedge clock);
            t++;
        end
        chk("dout_before_abort", 32'(n_dout >= 1), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_dout_valid", 32'(dout_valid), 32'd0);
        chk("abort_dout_re", 32'(dout_re), 32'd0);
        chk("abort_di_en", 32'(di_en), 32'd0);
        chk("abort_din_ready", 32'(din_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        exp_di.delete(); exp_out.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Fresh stream after abort must not see stale overlap data
        xs.delete();
        for (int i = 0; i < 16; i++) xs.push_back(16'(16'h0100 + 3 * i));
        run_stream(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
